serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 123 ++++++++++++
 tb/tb_serial_adder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder. Operands are captured on an accepted start
//   pulse and fed LSB-first, one bit pair per clock, through a one-bit full
//   adder whose carry is kept in a flip-flop between cycles. The completed
//   sum and carry are published together, so S/C_out never show partial
//   results.
//
//   Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed overflow
//   flag V (carry into the MSB XOR carry out of the MSB).
//
//   Ports:
//     clk    in   1      clock, all state changes on the rising edge
//     rst    in   1      synchronous active-high reset
//     start  in   1      request a new addition (accepted in IDLE or DONE)
//     A, B   in   WIDTH  operands, captured only when start is accepted
//     C_in   in   1      carry-in, captured only when start is accepted
//     S      out  WIDTH  sum of the last completed operation
//     C_out  out  1      carry-out of the last completed operation
//     busy   out  1      high while bits are being processed
//     done   out  1      one-cycle pulse when S/C_out are newly updated
//     V      out  1      signed overflow (only with SERIAL_ADDER_OVF_EN)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // One-bit full adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_adder(input logic a, input logic b,
                                            input logic ci);
    logic s;
    logic co;
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
    return {co, s};
  endfunction

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       fa;

  assign fa = full_adder(a_sh[0], b_sh[0], carry);

  // Status outputs decode the state register only; no input reaches them
  // combinationally.
  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      S      <= '0;
      C_out  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      V      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sh   <= A;
            b_sh   <= B;
            carry  <= C_in;
            cnt    <= '0;
            res_sh <= '0;
            state  <= ST_SHIFT;
          end else begin
            state  <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          // Sum bits enter at the MSB so that after WIDTH shifts bit 0 of
          // the operands has landed in bit 0 of the result.
          res_sh <= {fa[0], res_sh[WIDTH-1:1]};
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          carry  <= fa[1];
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            S     <= {fa[0], res_sh[WIDTH-1:1]};
            C_out <= fa[1];
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB on this edge.
            V     <= carry ^ fa[1];
`endif
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed bench for serial_adder (WIDTH=8) with hand-computed results.
//   Compile with SERIAL_ADDER_OVF_EN defined to also check the V flag.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       C_in;
  logic [7:0] S;
  logic       C_out;
  logic       busy;
  logic       done;
`ifdef SERIAL_ADDER_OVF_EN
  logic       V;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] prev_s;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .C_in  (C_in),
    .S     (S),
    .C_out (C_out),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .V     (V)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start one addition, scramble the operand inputs while it runs, and
  // check latency, busy length, hold of the old result, the new result
  // and the single-cycle done pulse.
  task automatic run_op(input string tag, input logic [7:0] a,
                        input logic [7:0] b, input logic ci,
                        input logic [7:0] es, input logic ec,
                        input logic ev);
    int lat;
    int nb;
    A = a; B = b; C_in = ci; start = 1'b1;
    tick();
    start = 1'b0;
    A = ~a; B = ~b; C_in = ~ci;
    nb  = busy ? 1 : 0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 4) chk({tag, "_hold"}, 32'(S), 32'(prev_s));
      if (done) begin
        lat = n;
        break;
      end
      if (busy) nb++;
    end
    chk({tag, "_lat"}, lat, 8);
    chk({tag, "_busy"}, nb, 8);
    chk({tag, "_S"}, 32'(S), 32'(es));
    chk({tag, "_C"}, 32'(C_out), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_V"}, 32'(V), 32'(ev));
`else
    if (ev === 1'bx) $display("note: unused overflow expectation");
`endif
    tick();
    chk({tag, "_pulse"}, 32'({done, busy}), 32'(0));
    chk({tag, "_keep"}, 32'(S), 32'(es));
    prev_s = es;
  endtask

  initial begin
    int ndone;
    int lat;
    logic [7:0] s_at_done;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; C_in = 1'b0;
    prev_s = 8'h00;
    tick();
    tick();
    chk("rst_S", 32'(S), 32'h00);
    chk("rst_C", 32'(C_out), 32'h0);
    chk("rst_ctl", 32'({busy, done}), 32'h0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_V", 32'(V), 32'h0);
`endif
    rst = 1'b0;
    tick();

    run_op("zero",  8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    run_op("cprop", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("cin",   8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    run_op("alt",   8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0);
    run_op("ovfp",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("ovfn",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op("negov", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);

    // Reset mid-operation: S=7F, C_out=1 beforehand, must clear.
    A = 8'hAA; B = 8'h55; C_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_done", 32'(done), 32'h0);
    chk("mrst_S", 32'(S), 32'h00);
    chk("mrst_C", 32'(C_out), 32'h0);
    ndone = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (done) ndone++;
    end
    chk("mrst_nodone", ndone, 0);
    prev_s = 8'h00;
    run_op("after", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

    // Start while busy is ignored.
    A = 8'h12; B = 8'h34; C_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    A = 8'hFF; B = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    s_at_done = 8'h00;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (done) begin
        ndone++;
        s_at_done = S;
        chk("ign_C", 32'(C_out), 32'h0);
      end
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_S", 32'(s_at_done), 32'h46);
    prev_s = 8'h46;

    // Back-to-back: second start issued during the DONE cycle.
    A = 8'h55; B = 8'hAA; C_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
    chk("b2b1_lat", lat, 8);
    chk("b2b1_S", 32'(S), 32'h00);
    chk("b2b1_C", 32'(C_out), 32'h1);
    A = 8'h01; B = 8'h02; C_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_acc", 32'({busy, done}), 32'h2);
    chk("b2b_holdS", 32'(S), 32'h00);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
    chk("b2b_gap", lat + 1, 9);
    chk("b2b2_S", 32'(S), 32'h03);
    chk("b2b2_C", 32'(C_out), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
